// File: rtl/pn_stack_evaluator.sv
// Stack-based evaluator for postfix/prefix token streams with a sticky error flag.
// Optional macro PN_DIV_EN enables operator code 3'd4 as signed division.
module pn_stack_evaluator #(
    parameter int MAX_TOKENS = 20,
    parameter int DW         = 64
) (
    input  logic          clk_2,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [2:0]    in,
    input  logic          operator,
    input  logic          mode,
    output logic          busy,
    output logic          out_valid,
    output logic [DW-1:0] out,
    output logic          err,
    output logic [1:0]    dbg_state
);

    localparam int SPW = $clog2(MAX_TOKENS + 1);
    localparam int CW  = $clog2(MAX_TOKENS + 2);
    localparam logic [SPW-1:0] SP_MAX  = SPW'(MAX_TOKENS);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_TOKENS);
    localparam logic [CW-1:0]  CNT_SAT = CW'(MAX_TOKENS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EVAL = 2'd2, DONE = 2'd3} state_t;

    // Handshake: a token is taken on every rising edge where in_valid=1 and busy=0;
    // tokens of one expression arrive on consecutive cycles and in_valid low ends it.
    state_t          state;
    logic            mode_q;
    logic            err_q;
    logic [SPW-1:0]  sp;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   rem;
    logic [DW-1:0]   stack  [MAX_TOKENS];
    logic [3:0]      buffer [MAX_TOKENS];

    logic            eff_mode;
    logic            accept;
    logic            in_room;
    logic            step_en;
    logic            step_err;
    logic            do_push;
    logic            tok_op;
    logic [2:0]      tok_val;
    logic [CW-1:0]   rd_idx;
    logic [SPW-1:0]  top_idx;
    logic [SPW-1:0]  nxt_idx;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic [DW-1:0]   diff;
    logic [DW-1:0]   alu_res;
    logic            alu_bad;
    logic            res_ok;

    assign dbg_state = state;
    assign eff_mode  = (state == IDLE) ? mode : mode_q;
    assign accept    = in_valid && (state == IDLE || state == LOAD);
    assign in_room   = cnt < CNT_MAX;
    assign step_en   = (state == EVAL && rem != '0) || (accept && in_room && !eff_mode);
    assign rd_idx    = (rem != '0) ? rem - CW'(1) : '0;
    assign top_idx   = (sp != '0) ? sp - SPW'(1) : '0;
    assign nxt_idx   = (sp >= SPW'(2)) ? sp - SPW'(2) : '0;
    assign res_ok    = !err_q && (sp == SPW'(1));

    always_comb begin
        tok_op  = operator;
        tok_val = in;
        if (state == EVAL) begin
            tok_op  = buffer[rd_idx][3];
            tok_val = buffer[rd_idx][2:0];
        end
    end

    // Postfix pops b first (top); prefix pops a first (top).
    always_comb begin
        opa = stack[nxt_idx];
        opb = stack[top_idx];
        if (state == EVAL) begin
            opa = stack[top_idx];
            opb = stack[nxt_idx];
        end
    end

    always_comb begin
        alu_res = '0;
        alu_bad = 1'b0;
        diff    = opa - opb;
        case (tok_val)
            3'd0: alu_res = opa + opb;
            3'd1: alu_res = diff;
            3'd2: alu_res = opa * opb;
            3'd3: alu_res = diff[DW-1] ? ('0 - diff) : diff;
`ifdef PN_DIV_EN
            3'd4: begin
                if (opb == '0) alu_bad = 1'b1;
                else           alu_res = DW'($signed(opa) / $signed(opb));
            end
`endif
            default: alu_bad = 1'b1;
        endcase
    end

    always_comb begin
        step_err = 1'b0;
        do_push  = 1'b0;
        if (tok_op) begin
            if (sp < SPW'(2) || alu_bad) step_err = 1'b1;
        end else if (sp >= SP_MAX) begin
            step_err = 1'b1;
        end else begin
            do_push = 1'b1;
        end
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            err_q     <= 1'b0;
            sp        <= '0;
            cnt       <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
            for (int i = 0; i < MAX_TOKENS; i++) begin
                stack[i]  <= '0;
                buffer[i] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
            case (state)
                IDLE, LOAD: begin
                    if (in_valid) begin
                        if (state == IDLE) begin
                            mode_q <= mode;
                            state  <= LOAD;
                        end
                        // Excess tokens are only counted, never stored.
                        if (!in_room)      err_q       <= 1'b1;
                        else if (eff_mode) buffer[cnt] <= {operator, in};
                        if (cnt != CNT_SAT) cnt <= cnt + CW'(1);
                    end else if (state == LOAD) begin
                        busy <= 1'b1;
                        if (mode_q) begin
                            state <= EVAL;
                            rem   <= err_q ? '0 : cnt;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out       <= res_ok ? stack[0] : '0;
                            err       <= !res_ok;
                        end
                    end
                end
                EVAL: begin
                    if (rem != '0) begin
                        rem <= rem - CW'(1);
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= res_ok ? stack[0] : '0;
                        err       <= !res_ok;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sp    <= '0;
                    cnt   <= '0;
                    err_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            if (step_en) begin
                if (step_err) begin
                    err_q <= 1'b1;
                end else if (do_push) begin
                    stack[sp] <= {{(DW-3){1'b0}}, tok_val};
                    sp        <= sp + SPW'(1);
                end else begin
                    stack[nxt_idx] <= alu_res;
                    sp             <= sp - SPW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pn_stack_evaluator.sv
// Directed bench for pn_stack_evaluator: postfix/prefix results, latency, errors, reset abort.
module tb_pn_stack_evaluator;

    localparam int DW = 64;

    logic          clk_2 = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    tok_in = 3'd0;
    logic          operator = 1'b0;
    logic          mode = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out;
    logic          err;
    logic [1:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] tok_q [$];

    pn_stack_evaluator #(.MAX_TOKENS(20), .DW(DW)) dut (
        .clk_2     (clk_2),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in        (tok_in),
        .operator  (operator),
        .mode      (mode),
        .busy      (busy),
        .out_valid (out_valid),
        .out       (out),
        .err       (err),
        .dbg_state (dbg_state)
    );

    always #5 clk_2 = ~clk_2;

    function automatic logic [3:0] num(input logic [2:0] v);
        return {1'b0, v};
    endfunction

    function automatic logic [3:0] opc(input logic [2:0] c);
        return {1'b1, c};
    endfunction

    // Mode is flipped after the first token; the design must ignore that.
    task automatic send_tokens(input logic m);
        for (int i = 0; i < tok_q.size(); i++) begin
            mode     = (i == 0) ? m : ~m;
            operator = tok_q[i][3];
            tok_in   = tok_q[i][2:0];
            in_valid = 1'b1;
            @(posedge clk_2);
            #1;
        end
        in_valid = 1'b0;
        operator = 1'b0;
        tok_in   = 3'd0;
        mode     = 1'b0;
        tok_q.delete();
    endtask

    task automatic wait_result(input string name, input logic [DW-1:0] exp_out,
                               input logic exp_err, input int exp_lat);
        int  lat;
        bit  seen;
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk_2);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no out_valid within 60 cycles", name);
        end else begin
            n_cmp++;
            if (out !== exp_out) begin
                n_fail++;
                $display("FAIL %s out: got %h expected %h", name, out, exp_out);
            end
            n_cmp++;
            if (err !== exp_err) begin
                n_fail++;
                $display("FAIL %s err: got %b expected %b", name, err, exp_err);
            end
            if (exp_lat > 0) begin
                n_cmp++;
                if (lat != exp_lat) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
                end
            end
            @(negedge clk_2);
            n_cmp++;
            if (out_valid !== 1'b0 || out !== '0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s pulse: out_valid=%b out=%h err=%b expected 0/0/0",
                         name, out_valid, out, err);
            end
        end
        @(posedge clk_2);
        #1;
    endtask

    task automatic run_expr(input logic m, input string name, input logic [DW-1:0] exp_out,
                            input logic exp_err, input int exp_lat);
        send_tokens(m);
        wait_result(name, exp_out, exp_err, exp_lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_2);
        @(negedge clk_2);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out !== '0 || err !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b out_valid=%b out=%h err=%b state=%0d expected all 0",
                     busy, out_valid, out, err, dbg_state);
        end
        rst_n = 1'b1;
        @(posedge clk_2);
        #1;
    endtask

    task automatic test_postfix();
        tok_q = '{num(3), num(4), opc(0), num(2), opc(2)};
        run_expr(1'b0, "postfix_34+2*", 64'd14, 1'b0, 2);
        tok_q = '{num(1), num(7), opc(1)};
        run_expr(1'b0, "postfix_17-", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 2);
        tok_q = '{num(7), num(3), opc(3)};
        run_expr(1'b0, "postfix_73absdiff", 64'd4, 1'b0, 2);
        tok_q = '{num(3), num(7), opc(3)};
        run_expr(1'b0, "postfix_37absdiff", 64'd4, 1'b0, 2);
        tok_q = '{num(6)};
        run_expr(1'b0, "postfix_single", 64'd6, 1'b0, 2);
    endtask

    task automatic test_prefix();
        tok_q = '{opc(1), opc(2), num(3), num(4), num(5)};
        run_expr(1'b1, "prefix_-*345", 64'd7, 1'b0, 8);
        tok_q = '{opc(1), num(2), num(5)};
        run_expr(1'b1, "prefix_-25", 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 6);
        tok_q = '{opc(0), num(3)};
        run_expr(1'b1, "prefix_underflow", 64'd0, 1'b1, 5);
    endtask

    task automatic test_errors();
        tok_q = '{num(5), opc(0)};
        run_expr(1'b0, "underflow", 64'd0, 1'b1, 2);
        for (int i = 0; i < 21; i++) tok_q.push_back(num(3'(i % 8)));
        run_expr(1'b0, "too_many_tokens", 64'd0, 1'b1, 2);
        tok_q = '{num(2), num(2), opc(0)};
        run_expr(1'b0, "after_overflow", 64'd4, 1'b0, 2);
        tok_q = '{num(1), num(2)};
        run_expr(1'b0, "depth_two", 64'd0, 1'b1, 2);
        tok_q = '{num(1), num(2), opc(6)};
        run_expr(1'b0, "illegal_op6", 64'd0, 1'b1, 2);
    endtask

    task automatic test_div();
`ifdef PN_DIV_EN
        tok_q = '{num(7), num(2), opc(4)};
        run_expr(1'b0, "div_7_2", 64'd3, 1'b0, 2);
`else
        tok_q = '{num(7), num(2), opc(4)};
        run_expr(1'b0, "div_7_2", 64'd0, 1'b1, 2);
`endif
        tok_q = '{num(7), num(0), opc(4)};
        run_expr(1'b0, "div_7_0", 64'd0, 1'b1, 2);
    endtask

    task automatic test_busy_ignore();
        tok_q = '{opc(2), num(6), num(7)};
        send_tokens(1'b1);
        @(posedge clk_2);
        #1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_eval: got %b expected 1", busy);
        end
        in_valid = 1'b1;
        operator = 1'b1;
        tok_in   = 3'd0;
        repeat (2) @(posedge clk_2);
        #1;
        in_valid = 1'b0;
        operator = 1'b0;
        wait_result("busy_ignore", 64'd42, 1'b0, 3);
    endtask

    task automatic test_back_to_back();
        tok_q = '{num(7), num(7), opc(2)};
        run_expr(1'b0, "b2b_first", 64'd49, 1'b0, 2);
        tok_q = '{opc(0), num(1), num(2)};
        run_expr(1'b1, "b2b_second", 64'd3, 1'b0, 6);
    endtask

    task automatic test_reset_mid_eval();
        bit spurious;
        tok_q = '{opc(1), opc(2), num(3), num(4), num(5)};
        send_tokens(1'b1);
        repeat (3) @(negedge clk_2);
        n_cmp++;
        if (busy !== 1'b1 || dbg_state !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_reset_eval: busy=%b state=%0d expected 1/2", busy, dbg_state);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out !== '0 || err !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b out_valid=%b out=%h err=%b state=%0d expected all 0",
                     busy, out_valid, out, err, dbg_state);
        end
        repeat (2) @(posedge clk_2);
        @(negedge clk_2);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk_2);
            if (out_valid === 1'b1) spurious = 1'b1;
        end
        n_cmp++;
        if (spurious) begin
            n_fail++;
            $display("FAIL no_output_after_reset: got out_valid=1 expected 0");
        end
        @(posedge clk_2);
        #1;
        tok_q = '{num(2), num(2), opc(0)};
        run_expr(1'b0, "after_reset", 64'd4, 1'b0, 2);
    endtask

    initial begin
        test_reset();
        test_postfix();
        test_prefix();
        test_errors();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_eval();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
